probe_measure_ctrl: RTL and testbench

//  Sequences one gated measurement of the logic-probe comparator pair (comp_data_hi/comp_data_lo) for the vf_meter CPU.
//  Per gate window it counts rising edges plus high/low/floating dwell cycles, latches the results and hands them
//  to the CPU with a valid/ack handshake. It also drives the four probe LEDs directly.

---
 rtl/vf_meter_pkg.sv | 38 +++
 rtl/probe_sync.sv | 39 +++
 rtl/probe_measure_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_probe_measure_ctrl.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vf_meter_pkg.sv
// Shared definitions for the vf_meter logic-probe measurement block.
// Contents:
//   state_t   - measurement sequencer states (IDLE/ARM/GATE/LATCH)
//   level_t   - classified probe level (FLOAT/HIGH/LOW)
//   SEL_*     - result_sel codes selecting which latched counter is read
//   classify  - maps the synced comparator pair onto a level; hi wins over lo
package vf_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_GATE  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        LVL_FLOAT = 2'd0,
        LVL_HIGH  = 2'd1,
        LVL_LOW   = 2'd2
    } level_t;

    localparam logic [1:0] SEL_EDGES = 2'd0;
    localparam logic [1:0] SEL_HIGH  = 2'd1;
    localparam logic [1:0] SEL_LOW   = 2'd2;
    localparam logic [1:0] SEL_FLOAT = 2'd3;

    // Both comparators set at once is treated as HIGH.
    function automatic level_t classify(input logic hi, input logic lo);
        if (hi) begin
            return LVL_HIGH;
        end
        if (lo) begin
            return LVL_LOW;
        end
        return LVL_FLOAT;
    endfunction

endpackage

// File: rtl/probe_sync.sv
// Two-flop synchronizer for the asynchronous comparator pair, followed by
// the level classifier.
// Ports:
//   clk, reset              - system clock, synchronous active-high reset
//   comp_data_hi/lo         - raw asynchronous comparator outputs
//   hi_s                    - synchronized high comparator (used for edge detect)
//   level                   - classified level of the synchronized pair
module probe_sync
    import vf_meter_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   comp_data_hi,
    input  logic   comp_data_lo,
    output logic   hi_s,
    output level_t level
);

    logic hi_meta;
    logic lo_meta;
    logic lo_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_meta <= 1'b0;
            lo_meta <= 1'b0;
            hi_s    <= 1'b0;
            lo_s    <= 1'b0;
        end else begin
            hi_meta <= comp_data_hi;
            lo_meta <= comp_data_lo;
            hi_s    <= hi_meta;
            lo_s    <= lo_meta;
        end
    end

    assign level = classify(hi_s, lo_s);

endmodule

// File: rtl/probe_measure_ctrl.sv
// Gated measurement sequencer for the logic-probe comparator pair.
// Each gate window counts rising edges of the synced high comparator plus
// the number of cycles spent HIGH, LOW and FLOATING, then latches the counts
// into result registers for the CPU. The four probe LEDs follow the live
// synced level independently of the sequencer.
//
// Handshake: result_valid rises one cycle after a LATCH and stays up until
// the CPU pulses ack, which clears result_valid and overrun on the next edge.
// A LATCH on the same cycle as ack takes priority (valid stays 1, overrun is
// left as it was). Latching while result_valid is already 1 sets the sticky
// overrun flag.
//
// Ports:
//   clk, reset         - system clock, synchronous active-high reset
//   comp_data_hi/lo    - asynchronous comparator inputs
//   start              - one-shot measurement request, honoured only in IDLE
//   continuous         - re-arm after every LATCH while set
//   ack                - CPU has consumed the results
//   result_sel         - selects edges / high / low / floating result
//   busy               - sequencer in ARM, GATE or LATCH
//   result_valid       - latched results available
//   overrun            - results overwritten before ack (sticky until ack)
//   result             - selected latched counter
//   led_one/zero/floating - registered live level indicators
//   led_pulse          - stretched activity indicator on any level change
//   fsm_state          - current sequencer state, for observation
module probe_measure_ctrl
    import vf_meter_pkg::*;
#(
    parameter int GATE_TICKS       = 800000,
    parameter int COUNTER_WIDTH    = 32,
    parameter int PULSE_HOLD_TICKS = 200000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     comp_data_hi,
    input  logic                     comp_data_lo,
    input  logic                     start,
    input  logic                     continuous,
    input  logic                     ack,
    input  logic [1:0]               result_sel,
    output logic                     busy,
    output logic                     result_valid,
    output logic                     overrun,
    output logic [COUNTER_WIDTH-1:0] result,
    output logic                     led_one,
    output logic                     led_zero,
    output logic                     led_floating,
    output logic                     led_pulse,
    output state_t                   fsm_state
);

    localparam int GATE_W = $clog2(GATE_TICKS);
    localparam int HOLD_W = $clog2(PULSE_HOLD_TICKS + 1);
    localparam logic [GATE_W-1:0]        GATE_LAST = GATE_W'(GATE_TICKS - 1);
    localparam logic [HOLD_W-1:0]        HOLD_LOAD = HOLD_W'(PULSE_HOLD_TICKS);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX   = '1;

    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + COUNTER_WIDTH'(1);
    endfunction

    logic   hi_s;
    level_t level;

    probe_sync u_probe_sync (
        .clk          (clk),
        .reset        (reset),
        .comp_data_hi (comp_data_hi),
        .comp_data_lo (comp_data_lo),
        .hi_s         (hi_s),
        .level        (level)
    );

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t state;
    state_t state_next;
    logic [GATE_W-1:0] gate_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = ST_ARM;
                end
            end
            ST_ARM:   state_next = ST_GATE;
            ST_GATE: begin
                if (gate_cnt == '0) begin
                    state_next = ST_LATCH;
                end
            end
            ST_LATCH: state_next = continuous ? ST_ARM : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Live counters, result registers and handshake flags
    // ------------------------------------------------------------------
    logic                     hi_s_d;
    logic [COUNTER_WIDTH-1:0] live_edges, live_high, live_low, live_float;
    logic [COUNTER_WIDTH-1:0] res_edges, res_high, res_low, res_float;

    always_ff @(posedge clk) begin
        if (reset) begin
            gate_cnt     <= '0;
            hi_s_d       <= 1'b0;
            live_edges   <= '0;
            live_high    <= '0;
            live_low     <= '0;
            live_float   <= '0;
            res_edges    <= '0;
            res_high     <= '0;
            res_low      <= '0;
            res_float    <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            case (state)
                ST_ARM: begin
                    // Priming hi_s_d here keeps a level that is already high
                    // from looking like an edge on the first gate cycle.
                    gate_cnt   <= GATE_LAST;
                    hi_s_d     <= hi_s;
                    live_edges <= '0;
                    live_high  <= '0;
                    live_low   <= '0;
                    live_float <= '0;
                end
                ST_GATE: begin
                    hi_s_d <= hi_s;
                    if (gate_cnt != '0) begin
                        gate_cnt <= gate_cnt - GATE_W'(1);
                    end
                    if (hi_s && !hi_s_d) begin
                        live_edges <= sat_inc(live_edges);
                    end
                    case (level)
                        LVL_HIGH: live_high  <= sat_inc(live_high);
                        LVL_LOW:  live_low   <= sat_inc(live_low);
                        default:  live_float <= sat_inc(live_float);
                    endcase
                end
                default: ;
            endcase

            if (state == ST_LATCH) begin
                res_edges    <= live_edges;
                res_high     <= live_high;
                res_low      <= live_low;
                res_float    <= live_float;
                result_valid <= 1'b1;
                if (result_valid && !ack) begin
                    overrun <= 1'b1;
                end
            end else if (ack) begin
                result_valid <= 1'b0;
                overrun      <= 1'b0;
            end
        end
    end

    always_comb begin
        result = res_edges;
        case (result_sel)
            SEL_EDGES: result = res_edges;
            SEL_HIGH:  result = res_high;
            SEL_LOW:   result = res_low;
            SEL_FLOAT: result = res_float;
            default:   result = res_edges;
        endcase
    end

    // ------------------------------------------------------------------
    // Probe LEDs: follow the live synced level regardless of the sequencer
    // ------------------------------------------------------------------
    level_t            level_d;
    logic [HOLD_W-1:0] hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            led_one      <= 1'b0;
            led_zero     <= 1'b0;
            led_floating <= 1'b0;
            level_d      <= LVL_FLOAT;
            hold         <= '0;
        end else begin
            led_one      <= (level == LVL_HIGH);
            led_zero     <= (level == LVL_LOW);
            led_floating <= (level == LVL_FLOAT);
            level_d      <= level;
            if (level != level_d) begin
                hold <= HOLD_LOAD;
            end else if (hold != '0) begin
                hold <= hold - HOLD_W'(1);
            end
        end
    end

    assign led_pulse = (hold != '0);

endmodule

// File: tb/tb_probe_measure_ctrl.sv
module tb_probe_measure_ctrl;
  import vf_meter_pkg::*;

  localparam int G      = 100;
  localparam int CW     = 16;
  localparam int H      = 8;
  localparam int SAT_CW = 6;
  localparam int WIN    = G + 2;
  localparam int HIST_N = 8192;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          comp_data_hi, comp_data_lo, start, continuous, ack;
  logic [1:0]    result_sel;
  logic          busy, result_valid, overrun;
  logic [CW-1:0] result;
  logic          led_one, led_zero, led_floating, led_pulse;
  state_t        fsm_state;

  logic              sat_hi, sat_lo, sat_start;
  logic [1:0]        sat_sel;
  logic              sat_busy, sat_valid, sat_overrun;
  logic [SAT_CW-1:0] sat_result;
  logic              sat_led_one, sat_led_zero, sat_led_floating, sat_led_pulse;
  state_t            sat_state;

  probe_measure_ctrl #(.GATE_TICKS(G), .COUNTER_WIDTH(CW), .PULSE_HOLD_TICKS(H)) dut (
    .clk(clk), .reset(reset), .comp_data_hi(comp_data_hi), .comp_data_lo(comp_data_lo),
    .start(start), .continuous(continuous), .ack(ack), .result_sel(result_sel),
    .busy(busy), .result_valid(result_valid), .overrun(overrun), .result(result),
    .led_one(led_one), .led_zero(led_zero), .led_floating(led_floating),
    .led_pulse(led_pulse), .fsm_state(fsm_state)
  );

  probe_measure_ctrl #(.GATE_TICKS(G), .COUNTER_WIDTH(SAT_CW), .PULSE_HOLD_TICKS(H)) dut_sat (
    .clk(clk), .reset(reset), .comp_data_hi(sat_hi), .comp_data_lo(sat_lo),
    .start(sat_start), .continuous(1'b0), .ack(1'b0), .result_sel(sat_sel),
    .busy(sat_busy), .result_valid(sat_valid), .overrun(sat_overrun), .result(sat_result),
    .led_one(sat_led_one), .led_zero(sat_led_zero), .led_floating(sat_led_floating),
    .led_pulse(sat_led_pulse), .fsm_state(sat_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- input history (index = clock edge number) ----------------
  int   cyc = 0;
  logic hist_hi [HIST_N];
  logic hist_lo [HIST_N];
  always @(posedge clk) begin
    if (cyc < HIST_N) begin
      hist_hi[cyc] = comp_data_hi;
      hist_lo[cyc] = comp_data_lo;
    end
    cyc = cyc + 1;
  end

  // ---------------- comparator stimulus: 0 hold, 1 square, 2 random ----------------
  int mode = 0;
  always @(negedge clk) begin
    case (mode)
      1: begin
        comp_data_hi = (((cyc / 5) % 2) == 0);
        comp_data_lo = ~comp_data_hi;
      end
      2: begin
        if ($urandom_range(0, 3) == 0) begin
          comp_data_hi = 1'($urandom_range(0, 1));
          comp_data_lo = 1'($urandom_range(0, 1));
        end
      end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] got [4];
  logic [CW-1:0] exp_v;

  // Window whose start request is sampled at edge s measures the inputs
  // present at edges s .. s+G-1; the edge before s decides whether the
  // first sample is a rising edge.
  task automatic model_window(input int s, input int w);
    int ne, nh, nl, nf, mx;
    ne = 0; nh = 0; nl = 0; nf = 0;
    mx = (1 << w) - 1;
    for (int i = s; i < s + G; i++) begin
      if (hist_hi[i]) nh++;
      else if (hist_lo[i]) nl++;
      else nf++;
      if (hist_hi[i] && !hist_hi[i-1]) ne++;
    end
    exp_q.push_back(CW'((ne > mx) ? mx : ne));
    exp_q.push_back(CW'((nh > mx) ? mx : nh));
    exp_q.push_back(CW'((nl > mx) ? mx : nl));
    exp_q.push_back(CW'((nf > mx) ? mx : nf));
  endtask

  task automatic read_results();
    for (int k = 0; k < 4; k++) begin
      result_sel = 2'(k);
      #1;
      got[k] = result;
    end
  endtask

  task automatic goto_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // Called on a negedge with result_valid low; returns start edge and the
  // number of edges until result_valid is first seen.
  task automatic run_window(output int s, output int lat);
    s = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!result_valid && (cyc - s) < 4 * G) @(negedge clk);
    lat = cyc - s;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({busy, result_valid, overrun} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {busy, result_valid, overrun});
    end
    checks++;
    if ({led_one, led_zero, led_floating, led_pulse} !== 4'b0000) begin
      errors++; $display("FAIL reset_leds: got %b expected 0000", {led_one, led_zero, led_floating, led_pulse});
    end
    checks++;
    if (fsm_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, ST_IDLE);
    end
    read_results();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== '0) begin
        errors++; $display("FAIL reset_result sel%0d: got %0d expected 0", k, got[k]);
      end
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_static_high();
    int s, lat;
    mode = 0;
    @(negedge clk);
    comp_data_hi = 1'b1; comp_data_lo = 1'b0;
    repeat (20) @(negedge clk);
    s = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL static_busy: got %b expected 1", busy);
    end
    while (!result_valid && (cyc - s) < 4 * G) @(negedge clk);
    lat = cyc - s;
    checks++;
    if (lat != G + 3) begin
      errors++; $display("FAIL static_latency: got %0d expected %0d", lat, G + 3);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL static_idle_after: got busy %b expected 0", busy);
    end
    model_window(s, CW);
    read_results();
    for (int k = 0; k < 4; k++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (got[k] !== exp_v) begin
        errors++; $display("FAIL static_result sel%0d: got %0d expected %0d", k, got[k], exp_v);
      end
    end
    checks++;
    if ({led_one, led_zero, led_floating, led_pulse} !== 4'b1000) begin
      errors++; $display("FAIL static_leds: got %b expected 1000", {led_one, led_zero, led_floating, led_pulse});
    end
    do_ack();
    checks++;
    if (result_valid !== 1'b0) begin
      errors++; $display("FAIL static_ack: got valid %b expected 0", result_valid);
    end
  endtask

  task automatic test_square();
    int s, lat, zeros;
    mode = 1;
    repeat (20) @(negedge clk);
    run_window(s, lat);
    checks++;
    if (lat != G + 3) begin
      errors++; $display("FAIL square_latency: got %0d expected %0d", lat, G + 3);
    end
    model_window(s, CW);
    read_results();
    for (int k = 0; k < 4; k++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (got[k] !== exp_v) begin
        errors++; $display("FAIL square_result sel%0d: got %0d expected %0d", k, got[k], exp_v);
      end
    end
    zeros = 0;
    repeat (30) begin
      @(negedge clk);
      if (led_pulse !== 1'b1) zeros++;
    end
    checks++;
    if (zeros != 0) begin
      errors++; $display("FAIL square_led_pulse: got %0d low samples expected 0", zeros);
    end
    do_ack();
  endtask

  task automatic test_floating();
    int s, lat;
    mode = 0;
    @(negedge clk);
    comp_data_hi = 1'b0; comp_data_lo = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if ({led_one, led_zero, led_floating, led_pulse} !== 4'b0010) begin
      errors++; $display("FAIL float_leds: got %b expected 0010", {led_one, led_zero, led_floating, led_pulse});
    end
    run_window(s, lat);
    model_window(s, CW);
    read_results();
    for (int k = 0; k < 4; k++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (got[k] !== exp_v) begin
        errors++; $display("FAIL float_result sel%0d: got %0d expected %0d", k, got[k], exp_v);
      end
    end
    do_ack();
    comp_data_hi = 1'b1; comp_data_lo = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({led_one, led_floating} !== 2'b10) begin
      errors++; $display("FAIL both_leds: got one/float %b expected 10", {led_one, led_floating});
    end
    run_window(s, lat);
    model_window(s, CW);
    read_results();
    for (int k = 0; k < 4; k++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (got[k] !== exp_v) begin
        errors++; $display("FAIL both_result sel%0d: got %0d expected %0d", k, got[k], exp_v);
      end
    end
    do_ack();
  endtask

  task automatic test_random();
    int s, lat;
    mode = 2;
    for (int w = 0; w < 3; w++) begin
      repeat ($urandom_range(3, 12)) @(negedge clk);
      run_window(s, lat);
      checks++;
      if (lat != G + 3) begin
        errors++; $display("FAIL random_latency w%0d: got %0d expected %0d", w, lat, G + 3);
      end
      model_window(s, CW);
      read_results();
      for (int k = 0; k < 4; k++) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (got[k] !== exp_v) begin
          errors++; $display("FAIL random_result w%0d sel%0d: got %0d expected %0d", w, k, got[k], exp_v);
        end
      end
      checks++;
      if (32'(got[1]) + 32'(got[2]) + 32'(got[3]) != G) begin
        errors++; $display("FAIL random_sum w%0d: got %0d expected %0d", w,
                           32'(got[1]) + 32'(got[2]) + 32'(got[3]), G);
      end
      do_ack();
    end
  endtask

  task automatic test_continuous();
    int s;
    mode = 2;
    continuous = 1'b1;
    s = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int w = 0; w < 4; w++) begin
      if (w == 2) begin
        // ack lands on the same edge as this window's LATCH
        goto_edge(s + 2 + G + w * WIN);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        continuous = 1'b0;
      end else begin
        goto_edge(s + 3 + G + w * WIN);
      end
      checks++;
      if (result_valid !== 1'b1) begin
        errors++; $display("FAIL cont_valid w%0d: got %b expected 1", w, result_valid);
      end
      checks++;
      if (overrun !== (w != 0)) begin
        errors++; $display("FAIL cont_overrun w%0d: got %b expected %b", w, overrun, (w != 0));
      end
      model_window(s + w * WIN, CW);
      read_results();
      for (int k = 0; k < 4; k++) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (got[k] !== exp_v) begin
          errors++; $display("FAIL cont_result w%0d sel%0d: got %0d expected %0d", w, k, got[k], exp_v);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL cont_stop: got busy %b expected 0", busy);
    end
    do_ack();
    checks++;
    if ({result_valid, overrun} !== 2'b00) begin
      errors++; $display("FAIL cont_lone_ack: got %b expected 00", {result_valid, overrun});
    end
  endtask

  task automatic test_reset_mid_window();
    int s, lat, rises;
    logic prev;
    mode = 2;
    run_window(s, lat);
    s = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    goto_edge(s + 52);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, result_valid, overrun} !== 3'b000) begin
      errors++; $display("FAIL midreset_flags: got %b expected 000", {busy, result_valid, overrun});
    end
    read_results();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== '0) begin
        errors++; $display("FAIL midreset_result sel%0d: got %0d expected 0", k, got[k]);
      end
    end
    repeat (5) @(negedge clk);
    // second start while busy must be ignored
    s = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rises = 0;
    prev = result_valid;
    while (cyc < s + 2 * WIN + 20) begin
      @(negedge clk);
      if (cyc == s + 30) start = 1'b1;
      else start = 1'b0;
      if (result_valid && !prev) rises++;
      prev = result_valid;
    end
    checks++;
    if (rises != 1) begin
      errors++; $display("FAIL busy_start rises: got %0d expected 1", rises);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL busy_start idle: got busy %b expected 0", busy);
    end
    model_window(s, CW);
    read_results();
    for (int k = 0; k < 4; k++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (got[k] !== exp_v) begin
        errors++; $display("FAIL busy_start_result sel%0d: got %0d expected %0d", k, got[k], exp_v);
      end
    end
    do_ack();
  endtask

  task automatic test_saturation();
    int s, mx;
    logic [SAT_CW-1:0] sexp [4];
    mx = (1 << SAT_CW) - 1;
    sexp[0] = '0;
    sexp[1] = SAT_CW'((G > mx) ? mx : G);
    sexp[2] = '0;
    sexp[3] = '0;
    s = cyc;
    sat_start = 1'b1;
    @(negedge clk);
    sat_start = 1'b0;
    while (!sat_valid && (cyc - s) < 4 * G) @(negedge clk);
    checks++;
    if (sat_valid !== 1'b1) begin
      errors++; $display("FAIL sat_valid: got %b expected 1", sat_valid);
    end
    for (int k = 0; k < 4; k++) begin
      sat_sel = 2'(k);
      #1;
      checks++;
      if (sat_result !== sexp[k]) begin
        errors++; $display("FAIL sat_result sel%0d: got %0d expected %0d", k, sat_result, sexp[k]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    comp_data_hi = 1'b0; comp_data_lo = 1'b0;
    start = 1'b0; continuous = 1'b0; ack = 1'b0; result_sel = 2'd0;
    sat_hi = 1'b1; sat_lo = 1'b0; sat_start = 1'b0; sat_sel = 2'd0;
    test_reset();
    test_static_high();
    test_square();
    test_floating();
    test_random();
    test_continuous();
    test_reset_mid_window();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
